input_buffer_streamer: RTL and testbench
========================================

Name: input_buffer_streamer

Overview:
Front-end staging buffer for the systolic array. It is the write-from-external / read-to-array counterpart of the output buffer. An external host loads operand words into a 16-entry buffer by address. On a start command, the block streams a contiguous, wrap-around address range into the array over a valid/ready handshake, one word per accepted beat, and reports busy/done.

Parameters:
DATA_W, 32, width of each buffer word and of the stream data.
DEPTH, 16, number of buffer entries (power of two).
ADDR_W, 4, address width, equal to log2(DEPTH).

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
ext_wr_en  input  1  external write strobe; writes on the rising edge.
ext_wr_addr  input  ADDR_W  external write address.
ext_wr_data  input  DATA_W  external write data.
start  input  1  one-cycle stream request.
start_addr  input  ADDR_W  first address to stream.
len  input  ADDR_W+1  number of words to stream (0..2*DEPTH-1).
data_to_array  output  DATA_W  stream data, held stable while data_valid=1 and array_ready=0.
data_valid  output  1  stream data valid.
array_ready  input  1  array accepts the beat when data_valid=1 and array_ready=1 at the rising edge.
busy  output  1  high from the cycle after an accepted start until the final beat is accepted.
done  output  1  one-cycle pulse after stream completion.

Behaviour:
- Reset (async assert, sync-safe deassert): data_to_array=0, data_valid=0, busy=0, done=0, state=IDLE, read pointer=0, remaining count=0. Buffer contents are not reset and are undefined after power-up.
- External writes are accepted in every state, including during streaming. Write latency is 1 cycle: the new word is readable from the next edge.
- States:
  - IDLE: busy=0. When start=1 and the effective length L>0 → STREAM. When start=1 and L=0 → IDLE with done=1 next cycle and no beats.
  - STREAM: busy=1.
- L = min(len, DEPTH). Values above DEPTH are clamped.
- Start latency: if start is sampled at edge T, then from edge T data_to_array=mem[start_addr], data_valid=1, pointer=start_addr+1, remaining=L-1.
- Beat advance: at a handshake edge with remaining>0, load mem[pointer], increment pointer modulo DEPTH (wraps 15→0), and decrement remaining. This gives back-to-back throughput of 1 word/cycle.
- Final beat: at the handshake edge with remaining=0: data_valid→0, busy→0, state→IDLE, done=1 for exactly the following cycle.
- Backpressure: while array_ready=0, data_to_array, data_valid, pointer and remaining hold.
- Read/write collision: when ext_wr_en targets the address being loaded into data_to_array at the same edge (including start_addr at the start edge), the old content is loaded (read-before-write). Writes to an address already loaded do not alter the held output.
- start while busy=1 is ignored and does not affect the current stream.
- start in the cycle done=1 is accepted normally.
- rst_n asserted mid-stream aborts immediately: outputs return to reset values and no done pulse is produced.

Decomposition:
- Shared package: DATA_W/DEPTH/ADDR_W defaults; state enum {IDLE, STREAM}.
- One sub-module: input_buf_mem, DEPTH x DATA_W storage with one synchronous write port and one combinational read port. No reset on storage.
- The streamer FSM, pointer, counter and output register live in the top.

Test Plan:
- Write mem[i]=0x100+i for i=0..15. start, start_addr=2, len=4, array_ready=1 → beats 0x102,0x103,0x104,0x105 on 4 consecutive cycles, busy 4 cycles, then done pulse once.
- start_addr=14, len=4, array_ready=1 → beats 0x10E,0x10F,0x100,0x101 (wrap-around).
- len=3 with array_ready toggling 1,0,0,1,1 → each word held stable while stalled; exactly 3 beats accepted; done after the third.
- start with len=0 → no data_valid, done=1 next cycle, busy stays 0. start with len=20 → exactly 16 beats.
- Same-edge ext_wr_en to start_addr=5 (data 0xDEAD) with start, len=2 → first beat is the old value 0x105. A second stream from addr 5 → 0xDEAD.
- Assert rst_n=0 mid-stream after 2 beats → data_valid/busy/done=0 immediately, no done pulse. A new start after release streams correctly.
- A second start during busy is ignored: beat count and data match the first command only.

Source files
------------

// File: rtl/input_buffer_streamer_pkg.sv
// input_buffer_streamer_pkg: shared defaults and FSM state type for the input buffer streamer.
package input_buffer_streamer_pkg;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  typedef enum logic {IDLE, STREAM} state_e;
endpackage

// File: rtl/input_buffer_streamer_mem.sv
// input_buf_mem: DEPTH x DATA_W storage, synchronous write, combinational read (read-before-write at an edge).
module input_buf_mem #(
  parameter int DATA_W = input_buffer_streamer_pkg::DATA_W,
  parameter int DEPTH  = input_buffer_streamer_pkg::DEPTH,
  parameter int ADDR_W = input_buffer_streamer_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/input_buffer_streamer.sv
// input_buffer_streamer: host-loaded 16-entry buffer streamed as a wrap-around address range
// over a valid/ready handshake, with busy/done status.
module input_buffer_streamer #(
  parameter int DATA_W = input_buffer_streamer_pkg::DATA_W,
  parameter int DEPTH  = input_buffer_streamer_pkg::DEPTH,
  parameter int ADDR_W = input_buffer_streamer_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ext_wr_en,
  input  logic [ADDR_W-1:0] ext_wr_addr,
  input  logic [DATA_W-1:0] ext_wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  output logic [DATA_W-1:0] data_to_array,
  output logic              data_valid,
  input  logic              array_ready,
  output logic              busy,
  output logic              done
);
  import input_buffer_streamer_pkg::*;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, rem_q, rem_d, rd_addr;
  logic [DATA_W-1:0] data_q, data_d, rd_data;
  logic              valid_q, valid_d, done_q, done_d;
  logic [ADDR_W:0]   eff_len;
  input_buf_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .wr_en   (ext_wr_en),
    .wr_addr (ext_wr_addr),
    .wr_data (ext_wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );
  assign eff_len = (len > DEPTH_L) ? DEPTH_L : len;
  // In IDLE the read port looks at start_addr so the first word loads on the start edge.
  assign rd_addr = (state_q == IDLE) ? start_addr : ptr_q;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start && eff_len != '0) begin
        state_d = STREAM;
        data_d  = rd_data;
        valid_d = 1'b1;
        ptr_d   = start_addr + 1'b1;
        rem_d   = ADDR_W'(eff_len - 1'b1);
      end else if (start) begin
        done_d  = 1'b1;
      end
    end else if (array_ready) begin
      if (rem_q != '0) begin
        data_d = rd_data;
        ptr_d  = ptr_q + 1'b1;
        rem_d  = rem_q - 1'b1;
      end else begin
        state_d = IDLE;
        valid_d = 1'b0;
        done_d  = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end
  assign data_to_array = data_q;
  assign data_valid    = valid_q;
  assign busy          = (state_q == STREAM);
  assign done          = done_q;
endmodule

// File: tb/tb_input_buffer_streamer.sv
// tb_input_buffer_streamer: directed and randomized streams checked against a shadow-buffer model.
module tb_input_buffer_streamer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ext_wr_en = 1'b0;
  logic [3:0]  ext_wr_addr = '0;
  logic [31:0] ext_wr_data = '0;
  logic        start = 1'b0;
  logic [3:0]  start_addr = '0;
  logic [4:0]  len = '0;
  logic [31:0] data_to_array;
  logic        data_valid;
  logic        array_ready = 1'b0;
  logic        busy;
  logic        done;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] shadow [16];
  logic [31:0] beats [$];

  input_buffer_streamer dut (
    .clk(clk), .rst_n(rst_n), .ext_wr_en(ext_wr_en), .ext_wr_addr(ext_wr_addr),
    .ext_wr_data(ext_wr_data), .start(start), .start_addr(start_addr), .len(len),
    .data_to_array(data_to_array), .data_valid(data_valid), .array_ready(array_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic        hv;
    logic [31:0] hd;
    hv = data_valid && !array_ready;
    hd = data_to_array;
    if (data_valid && array_ready) beats.push_back(data_to_array);
    @(posedge clk);
    #1;
    if (hv) begin
      check("stall_data", data_to_array, hd);
      check("stall_valid", data_valid, 1);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    ext_wr_en = 1'b1; ext_wr_addr = a; ext_wr_data = d;
    step();
    ext_wr_en = 1'b0;
    shadow[a] = d;
  endtask

  task automatic run_stream(input logic [3:0] sa, input logic [4:0] ln, input bit rnd,
                            input bit extra, input bit coll, input logic [31:0] cdata);
    logic [31:0] exp_q [$];
    int          l, cyc, busy_cyc;
    l = (ln > 16) ? 16 : int'(ln);
    for (int i = 0; i < l; i++) exp_q.push_back(shadow[(int'(sa) + i) % 16]);
    beats.delete();
    start = 1'b1; start_addr = sa; len = ln; array_ready = 1'b1;
    ext_wr_en = coll; ext_wr_addr = sa; ext_wr_data = cdata;
    step();
    start = 1'b0; ext_wr_en = 1'b0;
    if (coll) shadow[sa] = cdata;
    if (l == 0) begin
      check("len0_valid", data_valid, 0);
      check("len0_busy", busy, 0);
    end
    cyc = 0; busy_cyc = 0;
    while (!done && cyc < 200) begin
      array_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (extra && cyc == 1) begin
        start = 1'b1; start_addr = sa + 4'd3; len = 5'd7;
      end
      if (busy) busy_cyc++;
      if (busy !== data_valid) check("busy_eq_valid", busy, data_valid);
      step();
      start = 1'b0;
      cyc++;
    end
    check("done_seen", done, 1);
    check("busy_at_done", busy, 0);
    check("beat_count", beats.size(), l);
    for (int i = 0; i < l && i < beats.size(); i++) check("beat_data", beats[i], exp_q[i]);
    if (!rnd) check("busy_cycles", busy_cyc, l);
    array_ready = 1'b0;
    step();
    check("done_pulse_once", done, 0);
  endtask

  initial begin
    #2;
    check("rst_data", data_to_array, 0);
    check("rst_valid", data_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) wr(4'(i), 32'h100 + i);
    run_stream(4'd2, 5'd4, 0, 0, 0, 0);
    run_stream(4'd14, 5'd4, 0, 0, 0, 0);
    run_stream(4'd7, 5'd3, 1, 0, 0, 0);
    run_stream(4'd9, 5'd0, 0, 0, 0, 0);
    run_stream(4'd3, 5'd20, 0, 0, 0, 0);
    run_stream(4'd5, 5'd2, 0, 0, 1, 32'hDEAD);
    run_stream(4'd5, 5'd1, 0, 0, 0, 0);
    check("coll_new", beats.size() > 0 ? beats[0] : 32'hx, 32'hDEAD);
    run_stream(4'd1, 5'd6, 0, 1, 0, 0);
    // Abort mid-stream with reset after two accepted beats.
    start = 1'b1; start_addr = 4'd0; len = 5'd8; array_ready = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    check("abort_valid", data_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_data", data_to_array, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_no_done", done, 0);
    end
    run_stream(4'd12, 5'd5, 0, 0, 0, 0);
    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < 3; k++) wr(4'($urandom_range(0, 15)), $urandom);
      run_stream(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 1,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
